// File: rtl/fir_pkg.sv
// Shared definitions for the systolic FIR chain and its coefficient scheduler.
package fir_pkg;

  localparam int COEFF_W    = 16;
  localparam int B_WIDTH    = 16;
  localparam int BANK_GEN_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/fir_valid_pipe.sv
// Fixed-latency flag pipe that mirrors the MAC chain, one flag per cycle slot.
module fir_valid_pipe #(
  parameter int LATENCY = 20
) (
  input  logic clock,
  input  logic clear,
  input  logic din,
  output logic tail,
  output logic any_set
);

  logic [LATENCY-1:0] pipe;

  // Advance every cycle; a cleared pipe forgets everything in flight
  always_ff @(posedge clock) begin
    if (clear) begin
      pipe <= {LATENCY{1'b0}};
    end else begin
      pipe <= {pipe[LATENCY-2:0], din};
    end
  end

  assign tail = pipe[LATENCY-1];
  // Only flags that survive past this cycle count: the tail leaves on this edge
  assign any_set = |pipe[LATENCY-2:0];

endmodule

// File: rtl/fir_coeff_sched.sv
// Coefficient bank owner for the FIR chain: shadow writes, drain-and-swap commit,
// and sample tracking that masks results built from stale or warm-up state.
module fir_coeff_sched #(
  parameter int N_TAPS  = 16,
  parameter int COEFF_W = fir_pkg::COEFF_W,
  parameter int OUT_LAT = 20,
  parameter int ADDR_W  = $clog2(N_TAPS)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [ADDR_W-1:0]                 cfg_addr,
  input  logic [COEFF_W-1:0]                cfg_data,
  input  logic                              cfg_last,
  output logic                              cfg_err,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [N_TAPS*COEFF_W-1:0]         coeff_bus,
  output logic                              m_valid,
  output logic                              swap_done,
  output logic [fir_pkg::BANK_GEN_W-1:0]    bank_gen,
  output logic                              busy
);

  import fir_pkg::*;

  localparam logic [ADDR_W:0]   TAP_LIMIT = (ADDR_W+1)'(N_TAPS);
  localparam logic [ADDR_W-1:0] WARM_INIT = ADDR_W'(N_TAPS - 1);

  sched_state_e       state;
  logic [COEFF_W-1:0] shadow [N_TAPS];
  logic [ADDR_W-1:0]  warm;
  logic               accept_s;
  logic               accept_cfg;
  logic               addr_ok;
  logic               warm_zero;
  logic               occ_tail;
  logic               occ_any;
  logic               tag_tail;
  logic               tag_any;

  assign accept_s   = s_valid & s_ready;
  assign accept_cfg = cfg_valid & cfg_ready;
  assign addr_ok    = ({1'b0, cfg_addr} < TAP_LIMIT);
  assign warm_zero  = (warm == {ADDR_W{1'b0}});

  fir_valid_pipe #(.LATENCY(OUT_LAT)) u_occ (
    .clock   (clock),
    .clear   (reset),
    .din     (accept_s),
    .tail    (occ_tail),
    .any_set (occ_any)
  );

  fir_valid_pipe #(.LATENCY(OUT_LAT)) u_tag (
    .clock   (clock),
    .clear   (reset),
    .din     (accept_s & warm_zero),
    .tail    (tag_tail),
    .any_set (tag_any)
  );

  // A tagged slot is always occupied; gating with occ keeps the two pipes honest
  assign m_valid = tag_tail & occ_tail;

  // Scheduler FSM with banks, handshakes and status flags all registered here
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      cfg_ready <= 1'b1;
      s_ready   <= 1'b1;
      cfg_err   <= 1'b0;
      swap_done <= 1'b0;
      bank_gen  <= {BANK_GEN_W{1'b0}};
      busy      <= 1'b0;
      warm      <= WARM_INIT;
      coeff_bus <= {(N_TAPS*COEFF_W){1'b0}};
      for (int i = 0; i < N_TAPS; i++) begin
        shadow[i] <= {COEFF_W{1'b0}};
      end
    end else begin
      cfg_err   <= 1'b0;
      swap_done <= 1'b0;
      case (state)
        RUN: begin
          if (accept_s && !warm_zero) begin
            warm <= warm - ADDR_W'(1);
          end
          if (accept_cfg) begin
            if (addr_ok) begin
              shadow[cfg_addr] <= cfg_data;
            end else begin
              cfg_err <= 1'b1;
            end
            // Commit still proceeds when the final write itself was rejected
            if (cfg_last) begin
              state     <= DRAIN;
              cfg_ready <= 1'b0;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!occ_any && !tag_any) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          for (int i = 0; i < N_TAPS; i++) begin
            coeff_bus[i*COEFF_W +: COEFF_W] <= shadow[i];
          end
          swap_done <= 1'b1;
          bank_gen  <= bank_gen + BANK_GEN_W'(1);
          warm      <= WARM_INIT;
          state     <= RUN;
          cfg_ready <= 1'b1;
          s_ready   <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= RUN;
          cfg_ready <= 1'b1;
          s_ready   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_sched.sv
// Scoreboard bench for fir_coeff_sched: a 16-tap instance driven cycle by cycle
// against a timestamp model, plus a 12-tap instance for out-of-range writes.
module tb_fir_coeff_sched;

  localparam int N_TAPS  = 16;
  localparam int COEFF_W = 16;
  localparam int OUT_LAT = 20;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         cfg_valid, cfg_ready, cfg_last, cfg_err;
  logic [3:0]   cfg_addr;
  logic [15:0]  cfg_data;
  logic         s_valid, s_ready, m_valid, swap_done, busy;
  logic [255:0] coeff_bus;
  logic [7:0]   bank_gen;

  logic         cfg_valid_12, cfg_ready_12, cfg_last_12, cfg_err_12;
  logic [3:0]   cfg_addr_12;
  logic [15:0]  cfg_data_12;
  logic         s_valid_12, s_ready_12, m_valid_12, swap_done_12, busy_12;
  logic [191:0] coeff_bus_12;
  logic [7:0]   bank_gen_12;

  fir_coeff_sched #(.N_TAPS(16), .COEFF_W(16), .OUT_LAT(20)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .coeff_bus(coeff_bus),
    .m_valid(m_valid), .swap_done(swap_done), .bank_gen(bank_gen), .busy(busy)
  );

  fir_coeff_sched #(.N_TAPS(12), .COEFF_W(16), .OUT_LAT(20)) dut12 (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid_12), .cfg_ready(cfg_ready_12), .cfg_addr(cfg_addr_12),
    .cfg_data(cfg_data_12), .cfg_last(cfg_last_12), .cfg_err(cfg_err_12),
    .s_valid(s_valid_12), .s_ready(s_ready_12), .coeff_bus(coeff_bus_12),
    .m_valid(m_valid_12), .swap_done(swap_done_12), .bank_gen(bank_gen_12), .busy(busy_12)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state: event timestamps rather than a cycle-accurate copy
  int          swap_at;
  int          last_acc;
  int          n_since;
  int          bank_exp;
  logic [15:0] act_m [16];
  logic [15:0] shd_m [16];
  int          mv_q [$];
  int          err_q [$];

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [255:0] pack_bank();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = act_m[i];
    return v;
  endfunction

  task automatic model_reset();
    swap_at  = -10;
    last_acc = -100;
    n_since  = 0;
    bank_exp = 0;
    for (int i = 0; i < 16; i++) begin
      act_m[i] = 16'h0000;
      shd_m[i] = 16'h0000;
    end
    mv_q.delete();
    err_q.delete();
  endtask

  // One cycle: check this cycle's outputs, drive this cycle's inputs, advance model
  task automatic step(input logic sv, input logic cv, input logic [3:0] ca,
                      input logic [15:0] cd, input logic cl, input logic rst);
    logic exp_ready, exp_mv, exp_err, exp_sd;
    int   drain_end;
    @(negedge clock);
    exp_sd = (cyc == swap_at + 1);
    if (exp_sd) begin
      act_m    = shd_m;
      bank_exp = (bank_exp + 1) % 256;
      n_since  = 0;
    end
    exp_ready = (cyc > swap_at);
    exp_mv = (mv_q.size() > 0) && (mv_q[0] == cyc);
    if (exp_mv) void'(mv_q.pop_front());
    exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
    if (exp_err) void'(err_q.pop_front());

    check_val("s_ready",   256'(s_ready),   256'(exp_ready));
    check_val("cfg_ready", 256'(cfg_ready), 256'(exp_ready));
    check_val("busy",      256'(busy),      256'(!exp_ready));
    check_val("m_valid",   256'(m_valid),   256'(exp_mv));
    check_val("swap_done", 256'(swap_done), 256'(exp_sd));
    check_val("cfg_err",   256'(cfg_err),   256'(exp_err));
    check_val("bank_gen",  256'(bank_gen),  256'(bank_exp));
    check_val("coeff_bus", coeff_bus,       pack_bank());

    s_valid = sv; cfg_valid = cv; cfg_addr = ca; cfg_data = cd; cfg_last = cl; reset = rst;
    if (rst) begin
      model_reset();
    end else begin
      if (sv && exp_ready) begin
        if (n_since >= N_TAPS - 1) mv_q.push_back(cyc + OUT_LAT);
        n_since++;
        last_acc = cyc;
      end
      if (cv && exp_ready) begin
        if (int'(ca) < N_TAPS) shd_m[ca] = cd;
        else err_q.push_back(cyc + 1);
        if (cl) begin
          drain_end = last_acc + OUT_LAT + 1;
          swap_at = (cyc + 2 > drain_end) ? cyc + 2 : drain_end;
        end
      end
    end
    cyc++;
  endtask

  logic [191:0] exp12;

  initial begin
    reset = 1'b1;
    s_valid = 1'b0; cfg_valid = 1'b0; cfg_addr = 4'd0; cfg_data = 16'd0; cfg_last = 1'b0;
    s_valid_12 = 1'b0; cfg_valid_12 = 1'b0; cfg_addr_12 = 4'd0; cfg_data_12 = 16'd0;
    cfg_last_12 = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);

    // Warm-up: first 15 samples never flag, 16th flags OUT_LAT later
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // Full bank write while streaming, commit on tap 15
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 4'(i), 16'h0100 + 16'(i), (i == 15), 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // Quiet pipe, then repeated writes to tap 3; last write wins with sign bit set
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 16'h7FFF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 16'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // Reset, then commit with nothing ever accepted
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd0, 16'h0011, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // Gapped stream, commit together with a sample, reset in the 5th DRAIN cycle
    for (int i = 0; i < 30; i++) step((i % 3) != 0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd7, 16'h0777, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    // 12-tap build: in-range write, then out-of-range final write still commits
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    check_val("err12_idle", 256'(cfg_err_12), 256'(1'b0));
    cfg_valid_12 = 1'b1; cfg_addr_12 = 4'd2; cfg_data_12 = 16'h0042; cfg_last_12 = 1'b0;
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    check_val("err12_ok", 256'(cfg_err_12), 256'(1'b0));
    cfg_valid_12 = 1'b1; cfg_addr_12 = 4'd13; cfg_data_12 = 16'h1234; cfg_last_12 = 1'b1;
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    cfg_valid_12 = 1'b0; cfg_last_12 = 1'b0;
    check_val("err12_pulse", 256'(cfg_err_12), 256'(1'b1));
    check_val("ready12_drain", 256'(cfg_ready_12), 256'(1'b0));
    check_val("busy12_drain", 256'(busy_12), 256'(1'b1));
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    check_val("err12_clear", 256'(cfg_err_12), 256'(1'b0));
    check_val("sd12_swap", 256'(swap_done_12), 256'(1'b0));
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    exp12 = '0;
    exp12[2*16 +: 16] = 16'h0042;
    check_val("sd12_done", 256'(swap_done_12), 256'(1'b1));
    check_val("gen12", 256'(bank_gen_12), 256'(8'd1));
    check_val("bus12", 256'(coeff_bus_12), 256'(exp12));
    check_val("ready12_run", 256'(s_ready_12), 256'(1'b1));
    check_val("mv12", 256'(m_valid_12), 256'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
